// File: rtl/lab_logic_pkg.sv
// Shared truth-table type and named 2-input function tables for the lab logic blocks.
// Index convention: tt[{w,x}], so bit0 is wx=00 and bit3 is wx=11.
package lab_logic_pkg;

  typedef logic [3:0] tt_t;

  localparam tt_t TT_AND  = 4'b1000;
  localparam tt_t TT_OR   = 4'b1110;
  localparam tt_t TT_XOR  = 4'b0110;
  localparam tt_t TT_XNOR = 4'b1001;
  localparam tt_t TT_NAND = 4'b0111;
  localparam tt_t TT_NOR  = 4'b0001;

endpackage

// File: rtl/lf_tt_lut.sv
// Combinational bitwise 2-input LUT: each result bit y[i] is tt[{w[i],x[i]}].
module lf_tt_lut
  import lab_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       tt,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = tt[{w[i], x[i]}];
    end
  end

endmodule

// File: rtl/logic_func_pipe.sv
// Two-stage valid/ready pipeline evaluating a programmable 2-input function across WIDTH bits.
// Define LOGIC_FUNC_PARITY_EN to add the registered out_par (XOR-reduction of out_y).
module logic_func_pipe
  import lab_logic_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] TT_RESET = 4'b1110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_w,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
`ifdef LOGIC_FUNC_PARITY_EN
  output logic             out_par,
`endif
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] out_cnt
);

  tt_t              tt_q, tt_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_w_q, s1_w_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  tt_t              s1_tt_q, s1_tt_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lut_y;
  logic             s1_adv, s2_adv, accept, xfer;

  lf_tt_lut #(.WIDTH(WIDTH)) u_lut (
    .tt (s1_tt_q),
    .w  (s1_w_q),
    .x  (s1_x_q),
    .y  (lut_y)
  );

  // Ready propagates back combinationally so a drained S2 never costs a bubble.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign accept   = in_valid && s1_adv;
  assign xfer     = s2_valid_q && out_ready;
  assign in_ready = s1_adv;

  always_comb begin
    tt_d       = tt_q;
    s1_valid_d = s1_valid_q;
    s1_w_d     = s1_w_q;
    s1_x_d     = s1_x_q;
    s1_tt_d    = s1_tt_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    cnt_d      = cnt_q;

    if (cfg_we) tt_d = cfg_tt;

    // S1 snapshots the pre-write table, so a beat accepted alongside cfg_we uses the old one.
    if (s1_adv) s1_valid_d = in_valid;
    if (accept) begin
      s1_w_d  = in_w;
      s1_x_d  = in_x;
      s1_tt_d = tt_q;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) y_d = lut_y;
    end

    if (cnt_clr)   cnt_d = '0;
    else if (xfer) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_q       <= TT_RESET;
      s1_valid_q <= 1'b0;
      s1_w_q     <= '0;
      s1_x_q     <= '0;
      s1_tt_q    <= TT_RESET;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      cnt_q      <= '0;
    end else begin
      tt_q       <= tt_d;
      s1_valid_q <= s1_valid_d;
      s1_w_q     <= s1_w_d;
      s1_x_q     <= s1_x_d;
      s1_tt_q    <= s1_tt_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = y_q;
  assign out_cnt   = cnt_q;

`ifdef LOGIC_FUNC_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (s2_adv && s1_valid_q) par_d = ^lut_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_logic_func_pipe.sv
// Randomized and directed bench for logic_func_pipe against a transaction-level scoreboard.
// A second instance with CNT_W=2 shares all stimulus to exercise counter wrap.
module tb_logic_func_pipe;
  import lab_logic_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [3:0]   cfg_tt;
  logic         in_valid;
  logic [W-1:0] in_w, in_x;
  logic         out_ready;
  logic         cnt_clr;
  logic         in_ready, out_valid;
  logic [W-1:0] out_y;
  logic [15:0]  out_cnt;
  logic         in_ready2, out_valid2;
  logic [W-1:0] out_y2;
  logic [1:0]   out_cnt2;
`ifdef LOGIC_FUNC_PARITY_EN
  logic         out_par, out_par2;
`endif

  logic_func_pipe #(.WIDTH(W), .CNT_W(16), .TT_RESET(4'b1110)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
`ifdef LOGIC_FUNC_PARITY_EN
    .out_par(out_par),
`endif
    .cnt_clr(cnt_clr), .out_cnt(out_cnt)
  );

  logic_func_pipe #(.WIDTH(W), .CNT_W(2), .TT_RESET(4'b1110)) dut_c2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tt(cfg_tt),
    .in_valid(in_valid), .in_ready(in_ready2), .in_w(in_w), .in_x(in_x),
    .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2),
`ifdef LOGIC_FUNC_PARITY_EN
    .out_par(out_par2),
`endif
    .cnt_clr(cnt_clr), .out_cnt(out_cnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [3:0]   m_tt;
  logic [W-1:0] m_q[$];
  int           m_cnt;

  // per-cycle observations from tick
  logic         t_acc, t_xfer, t_par;
  logic [W-1:0] t_got, t_exp;

  // Sum of minterms: each table bit enables its own (w,x) combination.
  function automatic logic [W-1:0] ref_y(logic [3:0] tt, logic [W-1:0] w, logic [W-1:0] x);
    return ({W{tt[3]}} &  w &  x) | ({W{tt[2]}} &  w & ~x) |
           ({W{tt[1]}} & ~w &  x) | ({W{tt[0]}} & ~w & ~x);
  endfunction

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_tt = 4'h0; in_valid = 1'b0; in_w = '0; in_x = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  // Called just after a negedge with inputs set; observes handshakes, advances model, returns at next negedge.
  task automatic tick();
    #1;
    t_acc  = in_valid & in_ready;
    t_xfer = out_valid & out_ready;
    t_got  = out_y;
    t_exp  = 'x;
`ifdef LOGIC_FUNC_PARITY_EN
    t_par  = out_par;
`else
    t_par  = 1'b0;
`endif
    if (t_xfer && m_q.size() > 0) t_exp = m_q.pop_front();
    if (t_acc) m_q.push_back(ref_y(m_tt, in_w, in_x));
    if (cfg_we) m_tt = cfg_tt;
    if (cnt_clr)     m_cnt = 0;
    else if (t_xfer) m_cnt = (m_cnt + 1) & 32'hFFFF;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    m_q.delete(); m_tt = TT_OR; m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    m_q.delete(); m_tt = TT_OR; m_cnt = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_y !== 8'h00) begin bad++; $display("FAIL reset_out_y got=%h want=00", out_y); end
    total++; if (out_cnt !== 16'd0 || out_cnt2 !== 2'd0) begin bad++; $display("FAIL reset_out_cnt got=%0d/%0d want=0/0", out_cnt, out_cnt2); end
`ifdef LOGIC_FUNC_PARITY_EN
    total++; if (out_par !== 1'b0) begin bad++; $display("FAIL reset_out_par got=%0b want=0", out_par); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_default_or();
    in_valid = 1'b1; in_w = 8'hF0; in_x = 8'hCC; out_ready = 1'b1;
    tick();
    total++; if (t_acc !== 1'b1) begin bad++; $display("FAIL default_accept got=%0b want=1", t_acc); end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL default_latency1 got=%0b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_y !== 8'hFC) begin bad++; $display("FAIL default_or got=%0b/%h want=1/fc", out_valid, out_y); end
    tick();
    total++; if (t_xfer !== 1'b1 || t_got !== t_exp) begin bad++; $display("FAIL default_xfer got=%h want=%h", t_got, t_exp); end
    total++; if (out_cnt !== 16'd1) begin bad++; $display("FAIL default_cnt got=%0d want=1", out_cnt); end
  endtask

  task automatic test_cfg_boundary();
    logic [W-1:0] res[$];
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_tt = TT_XOR; in_valid = 1'b1; in_w = 8'hF0; in_x = 8'hCC;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (t_xfer) begin
        res.push_back(t_got);
        total++; if (t_got !== t_exp) begin bad++; $display("FAIL cfg_model got=%h want=%h", t_got, t_exp); end
      end
    end
    total++;
    if (res.size() != 2) begin bad++; $display("FAIL cfg_count got=%0d want=2", res.size()); end
    else if (res[0] !== 8'hFC || res[1] !== 8'h3C) begin
      bad++; $display("FAIL cfg_boundary got=%h,%h want=fc,3c", res[0], res[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bw[4], bx[4];
    logic [W-1:0] held;
    int n, got_n, first_x, last_x;
    logic [15:0] cnt0;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    cnt0 = out_cnt;
    cfg_we = 1'b1; cfg_tt = TT_NAND; tick(); cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin bw[i] = W'($urandom); bx[i] = W'($urandom); end
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_w = bw[n]; in_x = bx[n];
      tick();
      if (t_acc) n++;
      if (c == 2) held = out_y;
    end
    #1;
    total++; if (n != 2) begin bad++; $display("FAIL bp_accepts got=%0d want=2", n); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
    total++; if (out_y !== held || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h want=%h", out_y, held); end
    @(negedge clk);
    out_ready = 1'b1;
    got_n = 0; first_x = -1; last_x = -1;
    for (int c = 0; c < 12 && got_n < 4; c++) begin
      in_valid = (n < 4); in_w = (n < 4) ? bw[n] : '0; in_x = (n < 4) ? bx[n] : '0;
      tick();
      if (t_acc) n++;
      if (t_xfer) begin
        total++;
        if (t_got !== ref_y(TT_NAND, bw[got_n], bx[got_n])) begin
          bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", got_n, t_got, ref_y(TT_NAND, bw[got_n], bx[got_n]));
        end
        if (first_x < 0) first_x = c;
        last_x = c;
        got_n++;
      end
    end
    in_valid = 1'b0;
    total++; if (got_n != 4 || last_x - first_x != 3) begin bad++; $display("FAIL bp_nogap got=%0d span=%0d want=4 span=3", got_n, last_x - first_x); end
    total++; if (out_cnt !== cnt0 + 16'd4) begin bad++; $display("FAIL bp_cnt got=%0d want=%0d", out_cnt, cnt0 + 16'd4); end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] seq[5];
    int k, w;
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b1;
    k = 0; w = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      in_valid = (w < 5); in_w = W'($urandom); in_x = W'($urandom);
      tick();
      if (t_acc) w++;
      if (t_xfer) begin
        total++; if (out_cnt2 !== seq[k]) begin bad++; $display("FAIL cnt_wrap idx=%0d got=%0d want=%0d", k, out_cnt2, seq[k]); end
        k++;
      end
    end
    in_valid = 1'b0;
    total++; if (k != 5) begin bad++; $display("FAIL cnt_wrap_count got=%0d want=5", k); end
    in_valid = 1'b1; out_ready = 1'b0; tick(); in_valid = 1'b0;
    for (int c = 0; c < 5 && out_valid !== 1'b1; c++) tick();
    out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++; if (t_xfer !== 1'b1 || out_cnt2 !== 2'd0 || out_cnt !== 16'd0) begin
      bad++; $display("FAIL cnt_clr_wins got=%0b/%0d/%0d want=1/0/0", t_xfer, out_cnt2, out_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cfg_we = 1'b1; cfg_tt = TT_AND; tick(); cfg_we = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_w = 8'hA5; in_x = 8'h3C;
    tick(); tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    m_q.delete(); m_tt = TT_OR; m_cnt = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_cnt !== 16'd0 || out_y !== 8'h00) begin
      bad++; $display("FAIL midreset_async got=%0b/%0d/%h want=0/0/00", out_valid, out_cnt, out_y);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (t_xfer !== 1'b0) begin bad++; $display("FAIL midreset_stale got=%h want=none", t_got); end
    end
    in_valid = 1'b1; in_w = 8'hF0; in_x = 8'hCC;
    tick(); in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_y !== 8'hFC) begin bad++; $display("FAIL midreset_tt got=%h want=fc", out_y); end
    tick();
  endtask

  task automatic test_parity();
`ifdef LOGIC_FUNC_PARITY_EN
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_tt = TT_AND; tick(); cfg_we = 1'b0;
    in_valid = 1'b1; in_w = 8'hFF; in_x = 8'h07;
    tick(); in_valid = 1'b0;
    tick();
    total++; if (out_y !== 8'h07 || out_par !== 1'b1) begin bad++; $display("FAIL parity got=%h/%0b want=07/1", out_y, out_par); end
    tick();
`endif
  endtask

  task automatic test_random();
    logic [3:0] tabs[6];
    tabs[0] = TT_AND; tabs[1] = TT_OR; tabs[2] = TT_XOR;
    tabs[3] = TT_XNOR; tabs[4] = TT_NAND; tabs[5] = TT_NOR;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_w      = W'($urandom);
      in_x      = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_tt    = ($urandom_range(0, 1) == 0) ? tabs[$urandom_range(0, 5)] : 4'($urandom);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      tick();
      if (t_xfer) begin
        total++; if (t_got !== t_exp) begin bad++; $display("FAIL rand_y cyc=%0d got=%h want=%h", c, t_got, t_exp); end
`ifdef LOGIC_FUNC_PARITY_EN
        total++; if (t_par !== ^t_exp) begin bad++; $display("FAIL rand_par cyc=%0d got=%0b want=%0b", c, t_par, ^t_exp); end
`endif
      end
      total++; if (out_cnt !== 16'(m_cnt) || out_cnt2 !== 2'(m_cnt)) begin
        bad++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d want=%0d", c, out_cnt, out_cnt2, m_cnt);
      end
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (t_xfer) begin
        total++; if (t_got !== t_exp) begin bad++; $display("FAIL drain_y got=%h want=%h", t_got, t_exp); end
      end
    end
    total++; if (m_q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d left want=0", m_q.size()); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    m_q.delete(); m_tt = TT_OR; m_cnt = 0;
    test_reset();
    test_default_or();
    test_cfg_boundary();
    apply_reset();
    test_backpressure();
    test_counter_wrap();
    test_reset_mid();
    test_parity();
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_func_pipe.md
Name: logic_func_pipe

Overview:
- Parametrised, pipelined successor to the team's 2-input behavioural logic function.
- Evaluates any 2-input Boolean function, selected by a programmable 4-bit truth table, bitwise across WIDTH-bit operand vectors w and x.
- Two-stage valid/ready pipeline with full backpressure, plus a completed-transfer counter.
- Sits between a stimulus source and a result consumer in lab datapaths.

Parameters:
- WIDTH, 8, bits per operand vector (>=1).
- CNT_W, 16, width of the completed-transfer counter (>=1).
- TT_RESET, 4'b1110, truth table loaded on reset (OR function).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  truth-table write strobe.
- cfg_tt  in  4  new truth table, captured when cfg_we=1.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage 1 can accept a beat.
- in_w  in  WIDTH  operand w.
- in_x  in  WIDTH  operand x.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result vector.
- cnt_clr  in  1  synchronous clear of out_cnt.
- out_cnt  out  CNT_W  count of completed output transfers.

Behaviour:
- Reset (async, on rst=1): tt_q=TT_RESET; s1_valid=0; s2_valid=0; out_valid=0; out_y=0; out_cnt=0; in_ready=1 on the first cycle after release.
- Truth-table indexing: y[i] = tt[{w[i],x[i]}]; wx=00 selects bit0, 01 bit1, 10 bit2, 11 bit3.
- Stage 1 (S1) registers in_w, in_x and the current tt_q on accept (in_valid & in_ready).
- Stage 2 (S2) registers out_y = LUT(S1 tt, S1 w, S1 x); out_valid = s2_valid.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready, no bubble).
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput: 1 beat per cycle.
- Stall: when out_valid=1 and out_ready=0, out_y, S1 contents and valids hold. S1 fills, then in_ready drops. No beat is lost or duplicated.
- Config timing:
  - cfg_we updates tt_q at the clock edge.
  - A beat accepted in the same cycle as cfg_we uses the OLD table.
  - Beats already in the pipe keep the table they were captured with.
- Counter: out_cnt increments on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0. If cnt_clr and a transfer occur in the same cycle, clear wins (result 0).
- Reset mid-operation drops all in-flight beats immediately. Outputs go to their reset values asynchronously.
- in_valid may fall without a handshake; the block does not require it to stay asserted.

Optional Feature:
- Macro: LOGIC_FUNC_PARITY_EN.
- Defined: adds output out_par (1 bit) = XOR-reduction of out_y, registered in S2 alongside out_y, reset 0, held under stall.
- Undefined: no port and no parity logic; all other behaviour identical.

Decomposition:
- Package lab_logic_pkg holds:
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_XNOR=4'b1001, TT_NAND=4'b0111, TT_NOR=4'b0001;
  - typedef tt_t (4-bit logic).
- Sub-module lf_tt_lut: purely combinational WIDTH-bit LUT (tt, w, x -> y), instantiated once in S2.

Test Plan:
- Reset default, WIDTH=8: in_w=8'hF0, in_x=8'hCC, out_ready=1 -> out_y=8'hFC (OR) two cycles after accept; out_cnt=1.
- Table change at a beat boundary: cfg_tt=TT_XOR with cfg_we in the same cycle as beat A (w=8'hF0, x=8'hCC), beat B the same operands next cycle -> A yields 8'hFC, B yields 8'h3C.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts and out_y is stable. Release out_ready -> 4 results in order with no gaps, then out_cnt=4.
- Counter edge: CNT_W=2, 5 transfers -> out_cnt sequence 1,2,3,0,1. cnt_clr coincident with a transfer -> out_cnt=0.
- Async reset mid-stream: assert rst with 2 beats in flight -> out_valid=0, out_cnt=0, tt restored to 4'b1110 immediately. No stale result after release.
- With LOGIC_FUNC_PARITY_EN: TT_AND, w=8'hFF, x=8'h07 -> out_y=8'h07, out_par=1.
